// File: rtl/layer1_frame_ctrl.sv
// Frame sequencer for layer 1: streams one 28x28 image from a synchronous-read RAM
// into the conv+pool block, then waits for all pooled outputs or a drain timeout.
module layer1_frame_ctrl #(
   parameter int IMG_PIXELS    = 784,
   parameter int OUT_COUNT     = 144,
   parameter int ADDR_WIDTH    = 10,
   parameter int DRAIN_TIMEOUT = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  pause,
   input  logic                  weights_ready,
   output logic                  img_rd_en,
   output logic [ADDR_WIDTH-1:0] img_addr,
   input  logic [7:0]            img_q,
   output logic                  l1_valid_in,
   output logic [7:0]            l1_pixel_in,
   input  logic                  l1_result_valid,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [7:0]            out_cnt
);

   localparam int                    TO_WIDTH   = $clog2(DRAIN_TIMEOUT + 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(IMG_PIXELS - 1);
   localparam logic [7:0]            OUT_TARGET = 8'(OUT_COUNT);
   localparam logic [TO_WIDTH-1:0]   TO_LIMIT   = TO_WIDTH'(DRAIN_TIMEOUT);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_W,
      STREAM,
      DRAIN,
      DONE
   } state_t;

   state_t                state;
   state_t                state_next;
   logic [ADDR_WIDTH-1:0] pix_cnt;
   logic [TO_WIDTH-1:0]   to_cnt;
   logic [TO_WIDTH-1:0]   to_inc;
   logic [7:0]            out_cnt_next;
   logic                  launch;
   logic                  last_read;
   logic                  count_result;
   logic                  timeout_hit;
   logic                  frame_full;

   assign launch       = (state == IDLE) && start;
   assign last_read    = img_rd_en && (pix_cnt == LAST_ADDR);
   assign count_result = l1_result_valid && ((state == STREAM) || (state == DRAIN));
   assign out_cnt_next = (count_result && (out_cnt != 8'hFF)) ? out_cnt + 8'd1 : out_cnt;
   assign to_inc       = to_cnt + TO_WIDTH'(1);
   // Timeout is judged on the counter alone so it wins over a same-cycle final result.
   assign timeout_hit  = (state == DRAIN) && (to_inc == TO_LIMIT);
   assign frame_full   = (out_cnt_next >= OUT_TARGET);

   assign img_addr    = pix_cnt;
   assign l1_pixel_in = img_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = weights_ready ? STREAM : WAIT_W;
            end
         end
         WAIT_W: begin
            if (weights_ready) begin
               state_next = STREAM;
            end
         end
         STREAM: begin
            if (last_read) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (timeout_hit) begin
               state_next = IDLE;
            end else if (frame_full) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_comb begin
      img_rd_en = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      err       = 1'b0;
      case (state)
         IDLE:    busy      = 1'b0;
         STREAM:  img_rd_en = !pause;
         DRAIN:   err       = timeout_hit;
         DONE:    done      = 1'b1;
         default: busy      = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_cnt <= '0;
      end else if (launch) begin
         pix_cnt <= '0;
      end else if (img_rd_en) begin
         pix_cnt <= pix_cnt + ADDR_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_cnt <= 8'd0;
      end else if (launch) begin
         out_cnt <= 8'd0;
      end else begin
         out_cnt <= out_cnt_next;
      end
   end

   // Counts idle cycles between pooled results; only meaningful while draining.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt <= '0;
      end else if ((state == DRAIN) && !timeout_hit && !l1_result_valid) begin
         to_cnt <= to_inc;
      end else begin
         to_cnt <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         l1_valid_in <= 1'b0;
      end else begin
         l1_valid_in <= img_rd_en;
      end
   end

endmodule

// File: tb/tb_layer1_frame_ctrl.sv
// Testbench for layer1_frame_ctrl: random RAM contents and result timing, checked
// against frame-level arithmetic for read schedule, pixel stream, done/err and out_cnt.
module tb_layer1_frame_ctrl;

   localparam int IMG_PIXELS    = 784;
   localparam int OUT_COUNT     = 144;
   localparam int ADDR_WIDTH    = 10;
   localparam int DRAIN_TIMEOUT = 1024;
   localparam int NO_PAUSE      = 100000;

   logic                  clk;
   logic                  rst_n;
   logic                  start;
   logic                  pause;
   logic                  weights_ready;
   logic                  img_rd_en;
   logic [ADDR_WIDTH-1:0] img_addr;
   logic [7:0]            img_q;
   logic                  l1_valid_in;
   logic [7:0]            l1_pixel_in;
   logic                  l1_result_valid;
   logic                  busy;
   logic                  done;
   logic                  err;
   logic [7:0]            out_cnt;

   logic [7:0] mem [0:1023];

   int cyc;
   int checks;
   int passes;
   int prev_out;
   bit busy_prev;

   int rd_cyc[$];
   int rd_addr[$];
   int vl_cyc[$];
   int vl_pix[$];
   int done_q[$];
   int err_q[$];
   int rise_q[$];
   int fall_q[$];
   int res_q[$];
   bit res_plan[int];

   layer1_frame_ctrl #(
      .IMG_PIXELS   (IMG_PIXELS),
      .OUT_COUNT    (OUT_COUNT),
      .ADDR_WIDTH   (ADDR_WIDTH),
      .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .pause          (pause),
      .weights_ready  (weights_ready),
      .img_rd_en      (img_rd_en),
      .img_addr       (img_addr),
      .img_q          (img_q),
      .l1_valid_in    (l1_valid_in),
      .l1_pixel_in    (l1_pixel_in),
      .l1_result_valid(l1_result_valid),
      .busy           (busy),
      .done           (done),
      .err            (err),
      .out_cnt        (out_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (img_rd_en) begin
         img_q <= mem[img_addr];
      end
   end

   // Event recorder: timestamps every observable handshake mid-cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         if (img_rd_en) begin
            rd_cyc.push_back(cyc);
            rd_addr.push_back(int'(img_addr));
         end
         if (l1_valid_in) begin
            vl_cyc.push_back(cyc);
            vl_pix.push_back(int'(l1_pixel_in));
         end
         if (done) done_q.push_back(cyc);
         if (err) err_q.push_back(cyc);
         if (busy && !busy_prev) rise_q.push_back(cyc);
         if (!busy && busy_prev) fall_q.push_back(cyc);
      end
      busy_prev <= busy;
   end

   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) passes++;
      else begin
         $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   function automatic int rd_exp(input int f, input int k, input int pause_at, input int pause_len);
      return f + k + ((k >= pause_at) ? pause_len : 0);
   endfunction

   task automatic check_idle_zero(input string name);
      check_output({name, "/busy"},        32'(busy),        0);
      check_output({name, "/img_rd_en"},   32'(img_rd_en),   0);
      check_output({name, "/img_addr"},    32'(img_addr),    0);
      check_output({name, "/l1_valid_in"}, 32'(l1_valid_in), 0);
      check_output({name, "/done"},        32'(done),        0);
      check_output({name, "/err"},         32'(err),         0);
      check_output({name, "/out_cnt"},     32'(out_cnt),     0);
   endtask

   task automatic apply_idle_results(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         l1_result_valid = 1'b1;
      end
      tick();
      l1_result_valid = 1'b0;
      tick();
      check_output("idle_results/out_cnt", 32'(out_cnt), prev_out);
   endtask

   task automatic run_frame(input string name, input int wait_w, input int pause_at, input int pause_len,
                            input int n_results, input bit all_in_stream, input int restart_at,
                            input int abort_at);
      int s, f, last_rd, p0, k_stream, t, fin, stop;
      int exp_done, exp_err, exp_out, exp_rd, exp_vl, bad;
      bit aborted;
      for (int a = 0; a < 1024; a++) mem[a] = 8'($urandom);
      rd_cyc.delete(); rd_addr.delete(); vl_cyc.delete(); vl_pix.delete();
      done_q.delete(); err_q.delete(); rise_q.delete(); fall_q.delete();
      res_q.delete(); res_plan.delete();

      s       = cyc + 1;
      f       = s + wait_w + 1;
      last_rd = rd_exp(f, IMG_PIXELS - 1, pause_at, pause_len);
      p0      = f + pause_at;

      k_stream = all_in_stream ? n_results : int'($urandom_range(0, 40));
      if (k_stream > n_results) k_stream = n_results;
      for (int i = 0; i < k_stream; i++) begin
         t = all_in_stream ? f + 10 + i : f + 20 + i * 15 + int'($urandom_range(0, 5));
         res_q.push_back(t);
      end
      t = last_rd;
      for (int i = k_stream; i < n_results; i++) begin
         t += int'($urandom_range(1, 8));
         res_q.push_back(t);
      end
      foreach (res_q[i]) res_plan[res_q[i]] = 1'b1;

      exp_out = (n_results > 255) ? 255 : n_results;
      if (n_results >= OUT_COUNT) begin
         exp_done = (res_q[OUT_COUNT-1] > last_rd) ? res_q[OUT_COUNT-1] + 1 : last_rd + 2;
         exp_err  = -1;
         fin      = exp_done;
      end else begin
         exp_done = -1;
         exp_err  = ((n_results > 0 && res_q[n_results-1] > last_rd) ? res_q[n_results-1] : last_rd)
                    + DRAIN_TIMEOUT;
         fin      = exp_err;
      end
      stop    = (abort_at >= 0) ? rd_exp(f, abort_at, pause_at, pause_len) : fin + 2;
      aborted = 1'b0;

      for (int c = s; c <= stop; c++) begin
         tick();
         start           = (c == s) || (restart_at >= 0 && c == f + restart_at);
         weights_ready   = (c >= s + wait_w);
         pause           = (c >= p0) && (c < p0 + pause_len);
         l1_result_valid = (res_plan.exists(c) != 0);
         #1;
         if (pause_len > 0 && (c == p0 || c == p0 + pause_len - 1)) begin
            check_output({name, "/pause_addr"},  32'(img_addr),  pause_at);
            check_output({name, "/pause_rd_en"}, 32'(img_rd_en), 0);
         end
         if (abort_at >= 0 && c == stop) begin
            rst_n = 1'b0;
            #1;
            check_idle_zero({name, "/async_reset"});
            aborted = 1'b1;
         end
      end
      start           = 1'b0;
      pause           = 1'b0;
      l1_result_valid = 1'b0;
      weights_ready   = 1'b0;
      tick();
      if (aborted) begin
         tick();
         rst_n = 1'b1;
      end

      exp_rd = aborted ? abort_at : IMG_PIXELS;
      exp_vl = aborted ? abort_at - 1 : IMG_PIXELS;
      check_output({name, "/busy_rise"}, (rise_q.size() > 0) ? rise_q[0] : -1, s + 1);
      check_output({name, "/rd_count"}, rd_cyc.size(), exp_rd);
      bad = 0;
      for (int k = 0; k < rd_cyc.size() && k < exp_rd; k++) begin
         if (rd_cyc[k] != rd_exp(f, k, pause_at, pause_len) || rd_addr[k] != k) bad++;
      end
      check_output({name, "/rd_order"}, bad, 0);
      check_output({name, "/valid_count"}, vl_cyc.size(), exp_vl);
      bad = 0;
      for (int k = 0; k < vl_cyc.size() && k < exp_vl; k++) begin
         if (vl_cyc[k] != rd_exp(f, k, pause_at, pause_len) + 1 || vl_pix[k] != int'(mem[k])) bad++;
      end
      check_output({name, "/valid_pixels"}, bad, 0);
      if (aborted) begin
         check_output({name, "/done_count"}, done_q.size(), 0);
         check_output({name, "/err_count"},  err_q.size(),  0);
         prev_out = 0;
      end else begin
         check_output({name, "/done_count"}, done_q.size(), (exp_done >= 0) ? 1 : 0);
         check_output({name, "/done_cycle"}, (done_q.size() > 0) ? done_q[0] : -1, exp_done);
         check_output({name, "/err_count"},  err_q.size(),  (exp_err >= 0) ? 1 : 0);
         check_output({name, "/err_cycle"},  (err_q.size() > 0) ? err_q[0] : -1, exp_err);
         check_output({name, "/out_cnt"},    32'(out_cnt), exp_out);
         check_output({name, "/busy_fall"},  (fall_q.size() > 0) ? fall_q[0] : -1, fin + 1);
         prev_out = exp_out;
      end
      $display("[TB] frame %s finished at cycle %0d", name, cyc);
   endtask

   initial begin
      rst_n           = 1'b0;
      start           = 1'b0;
      pause           = 1'b0;
      weights_ready   = 1'b0;
      l1_result_valid = 1'b0;
      cyc             = 0;
      checks          = 0;
      passes          = 0;
      prev_out        = 0;
      tick();
      tick();
      check_idle_zero("reset");
      rst_n = 1'b1;
      tick();

      run_frame("basic",       0,  NO_PAUSE, 0,  144, 1'b0, -1,  -1);
      run_frame("wait_w",      50, NO_PAUSE, 0,  144, 1'b0, -1,  -1);
      run_frame("pause",       0,  300,      10, 144, 1'b0, -1,  -1);
      run_frame("timeout",     0,  NO_PAUSE, 0,  143, 1'b0, -1,  -1);
      apply_idle_results(3);
      run_frame("restart",     0,  NO_PAUSE, 0,  144, 1'b0, 100, -1);
      run_frame("abort",       0,  NO_PAUSE, 0,  144, 1'b0, -1,  400);
      run_frame("after_abort", 0,  NO_PAUSE, 0,  144, 1'b0, -1,  -1);
      run_frame("malformed",   0,  NO_PAUSE, 0,  260, 1'b1, -1,  -1);
      apply_idle_results(2);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/layer1_frame_ctrl.md
Name: layer1_frame_ctrl

Overview:
Sequences one 28x28 frame from a synchronous-read image RAM into the layer-1 conv+pool block. Gates streaming on the layer-1 weight-load completion. Counts pooled outputs (12x12 = 144) to detect frame completion. Provides start/busy/done/err handshakes to the top-level inference controller.

Parameters:
IMG_PIXELS, 784, pixels streamed per frame
OUT_COUNT, 144, pooled result_valid pulses expected per frame
ADDR_WIDTH, 10, image RAM address width
DRAIN_TIMEOUT, 1024, max cycles between results in DRAIN before abort

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle frame request
pause  in  1  host throttle; blocks new RAM reads while high
weights_ready  in  1  layer-1 weights/biases loaded
img_rd_en  out  1  image RAM read strobe
img_addr  out  ADDR_WIDTH  image RAM address
img_q  in  8  RAM read data, valid the cycle after img_rd_en
l1_valid_in  out  1  pixel strobe to layer 1
l1_pixel_in  out  8  pixel to layer 1
l1_result_valid  in  1  pooled-output strobe from layer 1
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse on frame completion
err  out  1  one-cycle pulse on drain timeout
out_cnt  out  8  pooled outputs received in the current frame

Behaviour:
- Reset values: all outputs 0, state IDLE, pixel counter 0, timeout counter 0.
- Read path timing: l1_valid_in is img_rd_en delayed by one register. l1_pixel_in = img_q, combinational pass-through.
- States: IDLE, WAIT_W, STREAM, DRAIN, DONE.

State transitions:
- IDLE: start=1 -> STREAM if weights_ready=1, else WAIT_W. Clear pixel counter and out_cnt on that edge. start is ignored in every other state; no queuing.
- WAIT_W: stay until weights_ready=1, then -> STREAM.
- STREAM: each cycle with pause=0:
  - img_rd_en=1, img_addr=pixel counter, counter increments.
  - Issuing address IMG_PIXELS-1 -> DRAIN next cycle.
  - pause=1: img_rd_en=0, address held. Any read already in flight is still delivered on l1_valid_in the next cycle.
  - First read occurs in the first STREAM cycle. The first l1_valid_in follows one cycle later.
  - Unpaused frame: exactly 784 consecutive l1_valid_in cycles.
- DRAIN: no reads. Timeout counter increments each cycle and clears on l1_result_valid.
  - Timeout counter reaching DRAIN_TIMEOUT -> err pulse in the same cycle, -> IDLE.
- Completion: out_cnt increments on every l1_result_valid in STREAM or DRAIN.
  - The cycle out_cnt becomes OUT_COUNT while in DRAIN -> DONE.
  - If OUT_COUNT is reached during STREAM (malformed frame), continue to DRAIN, then go straight to DONE.
- DONE: done=1 for exactly one cycle, busy=1, -> IDLE. out_cnt holds its final value until the next start.
- l1_result_valid in IDLE/WAIT_W/DONE is ignored; out_cnt is not modified.
- out_cnt saturates at 255.
- Drain timeout takes priority over completion only when both occur in the same cycle.
- Reset mid-frame: immediate return to IDLE, all outputs 0. No done or err pulse.

Test Plan:
- Reset, weights_ready=1, start pulse, RAM holds addr[7:0] -> img_addr 0..783 on consecutive cycles; l1_valid_in 784 cycles lagging by 1 with l1_pixel_in = addr LSBs; 144 result pulses -> done pulse exactly once; out_cnt=144; busy deasserts the cycle after done.
- weights_ready=0 at start, raised 50 cycles later -> no img_rd_en until the cycle after weights_ready rises; busy=1 throughout the wait.
- pause=1 for 10 cycles at pixel 300 -> img_addr holds at 300; exactly one l1_valid_in after pause rises (in-flight read), then none for the pause; total l1_valid_in still 784 with no duplicated or skipped address.
- Only 143 results returned -> err pulse DRAIN_TIMEOUT cycles after the last result; done never asserts; state IDLE; next start runs a clean frame.
- start re-pulsed during STREAM and result_valid pulsed in IDLE -> no restart; out_cnt unchanged by IDLE pulses.
- rst_n asserted at pixel 400 -> all outputs 0 asynchronously; after release, start yields a full frame from addr 0.
